// File: rtl/mw_pkg.sv
// Shared types and constants for the microwave controller slice.
// The optional done beep is enabled by defining MW_DONE_BEEP_EN.
package mw_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX         = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_RELOAD_TENS = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTING = 3'd1,
        ST_COOKING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/mw_bcd_dec.sv
// Combinational one-second decrement of an MM:SS BCD time, plus a flag
// raised when the decremented result is 00:00.
module mw_bcd_dec
    import mw_pkg::*;
(
    input  logic [DIGIT_W-1:0] min_tens,
    input  logic [DIGIT_W-1:0] min_ones,
    input  logic [DIGIT_W-1:0] sec_tens,
    input  logic [DIGIT_W-1:0] sec_ones,
    output logic [DIGIT_W-1:0] dec_min_tens,
    output logic [DIGIT_W-1:0] dec_min_ones,
    output logic [DIGIT_W-1:0] dec_sec_tens,
    output logic [DIGIT_W-1:0] dec_sec_ones,
    output logic               zero
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        dec_min_tens = min_tens;
        dec_min_ones = min_ones;
        dec_sec_tens = sec_tens;
        dec_sec_ones = sec_ones;

        if (sec_ones != '0) begin
            dec_sec_ones = sec_ones - 4'd1;
        end else if (sec_tens != '0) begin
            dec_sec_tens = sec_tens - 4'd1;
            dec_sec_ones = BCD_MAX;
        end else begin
            // Borrow a minute; seconds above 59 only ever count down, never reload there.
            dec_sec_tens = SEC_RELOAD_TENS;
            dec_sec_ones = BCD_MAX;
            if (min_ones != '0) begin
                dec_min_ones = min_ones - 4'd1;
            end else begin
                dec_min_ones = BCD_MAX;
                dec_min_tens = min_tens - 4'd1;
            end
        end

        zero = ~|{dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones};
    end

endmodule

// File: rtl/mw_controller.sv
// Microwave sequencer: keypad entry, MM:SS countdown, magnetron gating, done beep.
// Define MW_DONE_BEEP_EN to hold beep for DONE_TICKS ticks; otherwise DONE lasts one cycle.
module mw_controller
    import mw_pkg::*;
#(
    parameter int unsigned DONE_TICKS = 5
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [3:0] D,
    input  logic       pgt_1Hz,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic       enablen,
    output logic       mag_on,
    output logic       beep,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       cooking
);

    state_t     state, state_next;
    logic       pgt_q, en_q;
    logic [3:0] mt_n, mo_n, st_n, so_n;
    logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
    logic       dec_zero;
    logic       edge_evt, strobe, tick, key_ok, time_nz;

`ifdef MW_DONE_BEEP_EN
    logic [3:0] done_cnt, cnt_n;
`endif

    // The encoder mux output glitches when enablen flips, so that cycle's edge is dropped.
    assign edge_evt = pgt_1Hz & ~pgt_q & ~(enablen ^ en_q);
    assign strobe   = edge_evt & ~enablen;
    assign tick     = edge_evt & enablen;
    assign key_ok   = strobe && (D <= BCD_MAX);
    assign time_nz  = |{min_tens, min_ones, sec_tens, sec_ones};

    mw_bcd_dec u_dec (
        .min_tens     (min_tens),
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .dec_min_tens (dec_mt),
        .dec_min_ones (dec_mo),
        .dec_sec_tens (dec_st),
        .dec_sec_ones (dec_so),
        .zero         (dec_zero)
    );

    always_comb begin
        state_next = state;
        mt_n       = min_tens;
        mo_n       = min_ones;
        st_n       = sec_tens;
        so_n       = sec_ones;
`ifdef MW_DONE_BEEP_EN
        cnt_n      = done_cnt;
`endif

        case (state)
            ST_IDLE: begin
                if (stopn && key_ok) begin
                    {mt_n, mo_n, st_n, so_n} = {min_ones, sec_tens, sec_ones, D};
                    state_next = ST_SETTING;
                end
            end
            ST_SETTING: begin
                if (!stopn) begin
                    {mt_n, mo_n, st_n, so_n} = '0;
                    state_next = ST_IDLE;
                end else if (!startn && door_closed && time_nz) begin
                    state_next = ST_COOKING;
                end else if (key_ok) begin
                    {mt_n, mo_n, st_n, so_n} = {min_ones, sec_tens, sec_ones, D};
                end
            end
            ST_COOKING: begin
                if (!stopn || !door_closed) begin
                    state_next = ST_PAUSED;
                end else if (tick) begin
                    {mt_n, mo_n, st_n, so_n} = {dec_mt, dec_mo, dec_st, dec_so};
                    if (dec_zero) state_next = ST_DONE;
                end
            end
            ST_PAUSED: begin
                if (!stopn) begin
                    {mt_n, mo_n, st_n, so_n} = '0;
                    state_next = ST_IDLE;
                end else if (!startn && door_closed) begin
                    state_next = ST_COOKING;
                end
            end
            ST_DONE: begin
                if (!stopn) begin
                    state_next = ST_IDLE;
`ifdef MW_DONE_BEEP_EN
                end else if (tick) begin
                    if (done_cnt == 4'(DONE_TICKS - 1)) state_next = ST_IDLE;
                    else cnt_n = done_cnt + 4'd1;
                end
`else
                end else begin
                    state_next = ST_IDLE;
                end
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!clearn) begin
            state    <= ST_IDLE;
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
            pgt_q    <= 1'b0;
            en_q     <= 1'b0;
            enablen  <= 1'b0;
            mag_on   <= 1'b0;
            cooking  <= 1'b0;
        end else begin
            state    <= state_next;
            min_tens <= mt_n;
            min_ones <= mo_n;
            sec_tens <= st_n;
            sec_ones <= so_n;
            pgt_q    <= pgt_1Hz;
            en_q     <= enablen;
            enablen  <= (state_next == ST_COOKING) || (state_next == ST_PAUSED) ||
                        (state_next == ST_DONE);
            mag_on   <= (state_next == ST_COOKING);
            cooking  <= (state_next == ST_COOKING);
        end
    end

`ifdef MW_DONE_BEEP_EN
    always_ff @(posedge clk) begin
        if (!clearn) begin
            done_cnt <= '0;
            beep     <= 1'b0;
        end else begin
            done_cnt <= (state_next == ST_DONE) ? cnt_n : '0;
            beep     <= (state_next == ST_DONE);
        end
    end
`else
    assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_mw_controller.sv
// Self-checking bench for mw_controller: table-driven entry vectors, then
// hand-written countdown / pause / done / reset / mask sequences via a scoreboard.
`timescale 1ns/1ps
module tb_mw_controller;

    localparam int unsigned DONE_TICKS = 5;
`ifdef MW_DONE_BEEP_EN
    localparam logic BEEP_EN = 1'b1;
`else
    localparam logic BEEP_EN = 1'b0;
`endif

    logic       clk;
    logic       clearn;
    logic [3:0] D;
    logic       pgt_1Hz;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic       enablen, mag_on, beep, cooking;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

    mw_controller #(.DONE_TICKS(DONE_TICKS)) dut (
        .clk         (clk),
        .clearn      (clearn),
        .D           (D),
        .pgt_1Hz     (pgt_1Hz),
        .startn      (startn),
        .stopn       (stopn),
        .door_closed (door_closed),
        .enablen     (enablen),
        .mag_on      (mag_on),
        .beep        (beep),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .cooking     (cooking)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] t;
        logic        en;
        logic        mag;
        logic        bp;
        logic        ck;
    } obs_t;

    typedef enum { OP_KEY, OP_START, OP_START_OPEN, OP_STOP } op_e;

    typedef struct {
        op_e        op;
        logic [3:0] d;
        obs_t       exp;
        string      name;
    } vec_t;

    typedef struct {
        string name;
        obs_t  exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_assert = 0;
    int  n_fail   = 0;
    int  model_m, model_s;
    vec_t vecs[19];

    function automatic obs_t mk(logic [15:0] t, logic en, logic mag, logic bp, logic ck);
        return {t, en, mag, bp, ck};
    endfunction

    function automatic obs_t set_o(logic [15:0] t);  return mk(t, 1'b0, 1'b0, 1'b0, 1'b0); endfunction
    function automatic obs_t cook_o(logic [15:0] t); return mk(t, 1'b1, 1'b1, 1'b0, 1'b1); endfunction
    function automatic obs_t pause_o(logic [15:0] t); return mk(t, 1'b1, 1'b0, 1'b0, 1'b0); endfunction

    function automatic obs_t sample();
        return {min_tens, min_ones, sec_tens, sec_ones, enablen, mag_on, beep, cooking};
    endfunction

    function automatic logic [15:0] to_bcd(int m, int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_tick();
        if (model_s > 0) model_s--;
        else begin
            model_m--;
            model_s = 59;
        end
    endtask

    task automatic check(string nm, logic [19:0] act, logic [19:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h (time,en,mag,beep,cooking)", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_pop_check();
        sb_t item;
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL sb_empty: actual=none expected=entry");
        end else begin
            item = sb_q.pop_front();
            check(item.name, sample(), item.exp);
        end
    endtask

    task automatic drive_chk(string nm, obs_t e);
        sb_t item;
        item.name = nm;
        item.exp  = e;
        sb_q.push_back(item);
        step();
        sb_pop_check();
    endtask

    task automatic key(logic [3:0] d, string nm, obs_t e);
        D = d;
        pgt_1Hz = 1'b1;
        drive_chk(nm, e);
        pgt_1Hz = 1'b0;
        step();
    endtask

    task automatic tick(string nm, obs_t e);
        pgt_1Hz = 1'b1;
        drive_chk(nm, e);
        pgt_1Hz = 1'b0;
        step();
    endtask

    task automatic start(string nm, obs_t e);
        startn = 1'b0;
        drive_chk(nm, e);
        startn = 1'b1;
        step();
    endtask

    task automatic stop(string nm, obs_t e);
        stopn = 1'b0;
        drive_chk(nm, e);
        stopn = 1'b1;
        step();
    endtask

    task automatic apply_vec(vec_t v);
        case (v.op)
            OP_KEY:   key(v.d, v.name, v.exp);
            OP_START: start(v.name, v.exp);
            OP_STOP:  stop(v.name, v.exp);
            OP_START_OPEN: begin
                door_closed = 1'b0;
                startn      = 1'b0;
                drive_chk(v.name, v.exp);
                startn      = 1'b1;
                door_closed = 1'b1;
                step();
            end
            default: ;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{OP_KEY,        4'd1,  set_o(16'h0001), "key_1"};
        vecs[1]  = '{OP_KEY,        4'd3,  set_o(16'h0013), "key_3"};
        vecs[2]  = '{OP_KEY,        4'd0,  set_o(16'h0130), "key_0"};
        vecs[3]  = '{OP_STOP,       4'd0,  set_o(16'h0000), "stop_setting"};
        vecs[4]  = '{OP_KEY,        4'd1,  set_o(16'h0001), "key_1b"};
        vecs[5]  = '{OP_KEY,        4'd2,  set_o(16'h0012), "key_2"};
        vecs[6]  = '{OP_KEY,        4'd12, set_o(16'h0012), "key_invalid"};
        vecs[7]  = '{OP_KEY,        4'd3,  set_o(16'h0123), "key_3b"};
        vecs[8]  = '{OP_KEY,        4'd4,  set_o(16'h1234), "key_4"};
        vecs[9]  = '{OP_KEY,        4'd5,  set_o(16'h2345), "key_5"};
        vecs[10] = '{OP_KEY,        4'd6,  set_o(16'h3456), "key_drop_msd"};
        vecs[11] = '{OP_STOP,       4'd0,  set_o(16'h0000), "stop_clear"};
        vecs[12] = '{OP_KEY,        4'd0,  set_o(16'h0000), "key_zero"};
        vecs[13] = '{OP_START,      4'd0,  set_o(16'h0000), "start_time_zero"};
        vecs[14] = '{OP_KEY,        4'd1,  set_o(16'h0001), "key_1c"};
        vecs[15] = '{OP_KEY,        4'd3,  set_o(16'h0013), "key_3c"};
        vecs[16] = '{OP_KEY,        4'd0,  set_o(16'h0130), "key_0c"};
        vecs[17] = '{OP_START_OPEN, 4'd0,  set_o(16'h0130), "start_door_open"};
        vecs[18] = '{OP_START,      4'd0,  cook_o(16'h0130), "start_cook"};

        clearn      = 1'b0;
        D           = 4'd0;
        pgt_1Hz     = 1'b0;
        startn      = 1'b1;
        stopn       = 1'b1;
        door_closed = 1'b1;
        step();
        drive_chk("reset", set_o(16'h0000));
        clearn = 1'b1;
        step();

        for (int i = 0; i < 19; i++) apply_vec(vecs[i]);

        // Countdown from 01:30 down to 00:42 against an integer MM/SS model.
        model_m = 1;
        model_s = 30;
        for (int i = 1; i <= 48; i++) begin
            model_tick();
            tick("countdown", cook_o(to_bcd(model_m, model_s)));
            if (i == 30) check("at_0100", 20'({min_tens, min_ones, sec_tens, sec_ones}), 20'h0100);
            if (i == 31) check("at_0059", 20'({min_tens, min_ones, sec_tens, sec_ones}), 20'h0059);
        end

        // Door opens with a tick in the same cycle: tick discarded.
        door_closed = 1'b0;
        pgt_1Hz     = 1'b1;
        drive_chk("door_open_tick", pause_o(16'h0042));
        pgt_1Hz = 1'b0;
        step();
        for (int i = 0; i < 3; i++) tick("paused_tick", pause_o(16'h0042));
        door_closed = 1'b1;
        drive_chk("door_close", pause_o(16'h0042));
        start("resume", cook_o(16'h0042));
        model_tick();
        tick("resume_tick", cook_o(to_bcd(model_m, model_s)));
        while (!(model_m == 0 && model_s == 1)) begin
            model_tick();
            tick("countdown2", cook_o(to_bcd(model_m, model_s)));
        end

        // Last tick enters DONE; startn held low must not restart cooking.
        pgt_1Hz = 1'b1;
        drive_chk("done_entry", mk(16'h0000, 1'b1, 1'b0, BEEP_EN, 1'b0));
        pgt_1Hz = 1'b0;
        startn  = 1'b0;
        step();
`ifdef MW_DONE_BEEP_EN
        check("done_hold", sample(), mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
        for (int k = 1; k < DONE_TICKS; k++)
            tick("done_tick", mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
        tick("done_exit", set_o(16'h0000));
`else
        check("done_one_cycle", sample(), set_o(16'h0000));
`endif
        step();
        step();
        check("start_held_idle", sample(), set_o(16'h0000));
        startn = 1'b1;
        step();

        // startn and stopn together in SETTING: stop wins.
        key(4'd5, "key_5b", set_o(16'h0005));
        startn = 1'b0;
        stopn  = 1'b0;
        drive_chk("start_and_stop", set_o(16'h0000));
        startn = 1'b1;
        stopn  = 1'b1;
        step();

        // Synchronous clear in the middle of cooking.
        key(4'd2, "key_2b", set_o(16'h0002));
        start("start_short", cook_o(16'h0002));
        tick("short_tick", cook_o(16'h0001));
        clearn = 1'b0;
        drive_chk("clear_mid_cook", set_o(16'h0000));
        clearn = 1'b1;
        step();

        // Strobe in the cycle right after enablen falls is masked.
        key(4'd3, "key_3d", set_o(16'h0003));
        start("start_mask", cook_o(16'h0003));
        door_closed = 1'b0;
        drive_chk("door_open2", pause_o(16'h0003));
        stopn = 1'b0;
        drive_chk("stop_paused", set_o(16'h0000));
        stopn       = 1'b1;
        door_closed = 1'b1;
        D           = 4'd7;
        pgt_1Hz     = 1'b1;
        drive_chk("masked_strobe", set_o(16'h0000));
        pgt_1Hz = 1'b0;
        step();
        key(4'd7, "post_mask_strobe", set_o(16'h0007));

        // Seconds above 59 count down as entered; stop in COOKING only pauses.
        stop("stop_setting2", set_o(16'h0000));
        key(4'd1, "key_1e", set_o(16'h0001));
        key(4'd9, "key_9", set_o(16'h0019));
        key(4'd0, "key_0e", set_o(16'h0190));
        start("start_190", cook_o(16'h0190));
        tick("tick_190", cook_o(16'h0189));
        stop("stop_cooking", pause_o(16'h0189));
        stop("stop_paused2", set_o(16'h0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mw_controller.md
Name: mw_controller

Overview:
Central sequencer for the microwave. It drives the keypad encoder's enablen to choose between keypad-strobe mode and 1 Hz tick mode, and consumes that encoder's D and pgt_1Hz outputs. In keypad mode it shifts entered digits into a 4-digit BCD MM:SS register. In tick mode it counts the register down, gates the magnetron and sequences the done beep.

Parameters:
DONE_TICKS, 5, number of 1 Hz ticks beep stays high in DONE (1..15).

Ports:
clk  in  1  system clock; same clock as the encoder's debouncer and divider.
clearn  in  1  synchronous active-low reset.
D  in  4  encoded key value from the encoder; valid on a strobe.
pgt_1Hz  in  1  encoder mux output: key strobe when enablen=0, 1 Hz tick when enablen=1.
startn  in  1  start button, active-low, level.
stopn  in  1  stop/clear button, active-low, level.
door_closed  in  1  1 = door closed.
enablen  out  1  to the encoder: 0 = keypad mode, 1 = tick mode.
mag_on  out  1  magnetron enable.
beep  out  1  done indicator.
min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD time for display.
cooking  out  1  1 while in COOKING.

Behaviour:
- Reset: clk is the only clock. Reset is synchronous and active-low on clearn, sampled at the rising edge of clk. On reset:
  - state=IDLE, all digits=0
  - enablen=0, mag_on=0, beep=0, cooking=0
  - edge-detect register=0, beep counter=0
- Reset mid-cook takes effect on the next edge with no residual outputs.
- Edge detection: event = pgt_1Hz & ~pgt_q, with pgt_q registered every cycle.
  - In the cycle after enablen changes value, the event is masked so mux switching cannot create a false edge.
  - A strobe is an event while enablen=0. A tick is an event while enablen=1.
- Entry: on a strobe with D<=9, digits shift left (min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D). The old min_tens is discarded. A strobe with D>9 is ignored.
- Decrement, one per tick in COOKING:
  - If sec_ones≠0: sec_ones-1.
  - Else if sec_tens≠0: sec_tens-1, sec_ones=9.
  - Else: borrow one minute (BCD, min_ones 0→9 with min_tens-1) and seconds reload to 59.
  - Entered seconds above 59 are legal and count down as entered (1:90 → 1:89 …).
- FSM, states IDLE, SETTING, COOKING, PAUSED, DONE. Priority within a cycle: clearn > stopn > door/start > tick/strobe.
  - IDLE: enablen=0. A valid strobe shifts the digit and moves to SETTING. startn is ignored.
  - SETTING: enablen=0.
    - Valid strobe: shift, stay.
    - stopn=0: clear digits, go to IDLE.
    - startn=0 & door_closed & time≠0: go to COOKING.
    - startn with door open or time=0: ignored.
  - COOKING: enablen=1, cooking=1, mag_on=1.
    - Door opens or stopn=0: go to PAUSED; any tick in that same cycle is discarded.
    - Tick: decrement; if the result is 00:00, go to DONE.
  - PAUSED: enablen=1, mag_on=0, ticks ignored, time held.
    - stopn=0: clear digits, go to IDLE.
    - startn=0 & door_closed: go to COOKING.
  - DONE: enablen=1, mag_on=0, digits=0, beep=1.
    - Counter counts ticks; after DONE_TICKS ticks, go to IDLE.
    - stopn=0: go to IDLE immediately.
    - Keys are ignored.
- Output timing: all outputs are registered. mag_on drops on the clock edge following door_closed=0.
- Button levels: startn and stopn are level inputs. Holding startn does not re-trigger after COOKING→DONE, because DONE ignores startn.

Optional Feature:
- Macro: MW_DONE_BEEP_EN.
- Defined: DONE behaves as above (beep for DONE_TICKS ticks).
- Undefined: DONE lasts exactly one cycle and then goes to IDLE. beep is tied to 0, the beep counter and DONE_TICKS are unused, and the counter is not synthesized.

Decomposition:
- Package mw_pkg holds:
  - state enum encoding (3 bits)
  - BCD_MAX=9, SEC_RELOAD_TENS=5
  - digit width constant 4
- Sub-module mw_bcd_dec: combinational MM:SS BCD decrement plus a zero-result flag, instantiated once.

Test Plan:
1. Reset, then strobes D=1,3,0 → digits 0,1,3,0 (01:30), state SETTING, enablen=0, mag_on=0.
2. Strobes D=1,2,3,4,5 → 23:45. A strobe with D=12 in between → no change.
3. From 01:30, door closed, pulse startn → enablen=1, mag_on=1. 30 ticks → 01:00; next tick → 00:59.
4. Open the door at 00:42 → PAUSED, mag_on=0 next edge. 3 ticks leave the time at 00:42. Close the door and pulse startn → COOKING; next tick → 00:41.
5. At 00:01 one tick → 00:00, DONE, beep=1 for 5 ticks (MW_DONE_BEEP_EN defined), then IDLE with enablen=0. Macro undefined: beep stays 0 and IDLE is reached next cycle.
6. startn=0 and stopn=0 in the same cycle in SETTING → IDLE, digits 0. clearn=0 mid-COOKING → all outputs at reset values after one edge. A key strobe arriving in the cycle right after enablen toggles is masked.
